halt_monitor: RTL and testbench
===============================

Name: halt_monitor

Overview:
- Synthesizable monitor that sits directly downstream of dut_soc and consumes its halt and firstWord outputs.
- Counts cycles from power-on, captures the first halt event (word and cycle), and runs optional integrity checks while halted.
- Signals completion or a coded failure, so the simulation top and FPGA bring-up logic read one result interface.

Parameters:
- TIMEOUT_CYCLES, 3000: cycle count that, when exceeded without halt, is a failure (only when checkEn=1).
- SETTLE_CYCLES, 5: cycles after the halt capture cycle before done asserts; legal range 1..255.
- CNT_WIDTH, 32: width of the cycle counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- pwrOn  input  1  asynchronous active-low reset (0 = reset, 1 = run).
- halt  input  1  halt flag from dut_soc.
- firstWord  input  16  first-word observation bus from dut_soc.
- checkEn  input  1  enables the timeout, halt-drop and word-change checks; sampled every cycle.
- done  output  1  run finished successfully (sticky).
- fail  output  1  check failed (sticky).
- errCode  output  2  0 none, 1 timeout, 2 halt de-asserted, 3 firstWord changed.
- wordAtHalt  output  16  firstWord captured on the first halt.
- clkAtHalt  output  CNT_WIDTH  cycle number of the first halt.
- clkCnt  output  CNT_WIDTH  rising edges counted since reset release; freezes in DONE/FAIL.

Behaviour:
- Reset (pwrOn=0, asynchronous, any state including mid-settle):
  - state=RUN; clkCnt, clkAtHalt, wordAtHalt, errCode and the settle counter go to 0; done=fail=0.
- Release is synchronous to clk. The first rising edge with pwrOn=1 makes clkCnt=1.
- States: RUN, HALTED, DONE, FAIL. All outputs are registered, with no combinational path from inputs.
- clkCnt: cntNext=clkCnt+1 on every edge in RUN/HALTED. It saturates at all-ones and does not wrap.
- RUN:
  - halt=1: wordAtHalt<=firstWord, clkAtHalt<=cntNext, settle<=0, go to HALTED.
  - Otherwise, checkEn=1 and cntNext>TIMEOUT_CYCLES: errCode<=1, fail<=1, go to FAIL.
  - Halt has priority over timeout on the same edge.
- HALTED, on each edge:
  - settle<=settle+1.
  - If checkEn and halt=0: errCode<=2, go to FAIL.
  - Else if checkEn and firstWord!=wordAtHalt: errCode<=3, go to FAIL.
  - Else if settle+1==SETTLE_CYCLES: done<=1, go to DONE.
  - Errors take priority over completion on the same edge.
  - With checkEn=0, halt dropping or firstWord changing is ignored and captured values are not re-taken.
- Successful finish: clkCnt == clkAtHalt+SETTLE_CYCLES and done is visible on that same edge.
- DONE/FAIL: terminal until reset; all outputs hold; inputs ignored.
- done and fail are never both 1. errCode is nonzero iff fail=1.
- Only the first halt is captured; later halts never update wordAtHalt or clkAtHalt.

Test Plan:
- halt rises so that the capture edge is clkCnt=100 with firstWord=0x1234, held steady, checkEn=1 -> wordAtHalt=0x1234, clkAtHalt=100; done=1 at clkCnt=105; fail=0, errCode=0.
- halt never asserted, checkEn=1 -> fail=1 and errCode=1 with clkCnt frozen at 3001. With checkEn=0 instead -> no fail, and clkCnt still counting at 5000.
- Halt captured at 50, then halt=0 on the edge at 52, checkEn=1 -> fail=1, errCode=2, clkCnt=52, done never asserts.
- Halt captured at 50 with 0xBEEF, firstWord=0xBEEE at 53 -> errCode=3. Same stimulus with checkEn=0 -> done at 55, wordAtHalt=0xBEEF.
- halt arrives on the edge where cntNext=3001, checkEn=1 -> halt wins: clkAtHalt=3001, done at 3006.
- pwrOn pulsed low at clkCnt=52 while HALTED -> all outputs 0 immediately (asynchronous). After release, a halt at edge 10 completes with done at 15.

Source files
------------

// File: rtl/halt_monitor.sv
// Result monitor for dut_soc: counts cycles from reset release, captures the first halt,
// runs optional integrity checks while halted, then reports done or a coded failure.
module halt_monitor #(
    parameter int TIMEOUT_CYCLES = 3000,
    parameter int SETTLE_CYCLES  = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 pwrOn,
    input  logic                 halt,
    input  logic [15:0]          firstWord,
    input  logic                 checkEn,
    output logic                 done,
    output logic                 fail,
    output logic [1:0]           errCode,
    output logic [15:0]          wordAtHalt,
    output logic [CNT_WIDTH-1:0] clkAtHalt,
    output logic [CNT_WIDTH-1:0] clkCnt
);

    typedef enum logic [1:0] {
        RUN,
        HALTED,
        DONE,
        FAIL
    } stateT;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [7:0]           SETTLE_LAST   = 8'(SETTLE_CYCLES);

    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_DROP    = 2'd2;
    localparam logic [1:0] ERR_WORD    = 2'd3;

    stateT                stateReg;
    logic [7:0]           settleReg;
    logic [7:0]           settleNext;
    logic [CNT_WIDTH-1:0] cntNext;

    // Saturating increment: a run that never halts must not wrap back to small counts.
    assign cntNext    = (&clkCnt) ? clkCnt : clkCnt + CNT_WIDTH'(1);
    assign settleNext = settleReg + 8'd1;

    always_ff @(posedge clk or negedge pwrOn) begin
        if (!pwrOn) begin
            stateReg   <= RUN;
            settleReg  <= 8'd0;
            clkCnt     <= '0;
            clkAtHalt  <= '0;
            wordAtHalt <= 16'd0;
            errCode    <= 2'd0;
            done       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            unique case (stateReg)
                RUN: begin
                    clkCnt <= cntNext;
                    if (halt) begin
                        wordAtHalt <= firstWord;
                        clkAtHalt  <= cntNext;
                        settleReg  <= 8'd0;
                        stateReg   <= HALTED;
                    end else if (checkEn && (cntNext > TIMEOUT_LIMIT)) begin
                        errCode  <= ERR_TIMEOUT;
                        fail     <= 1'b1;
                        stateReg <= FAIL;
                    end
                end
                HALTED: begin
                    clkCnt    <= cntNext;
                    settleReg <= settleNext;
                    // Integrity errors outrank completion landing on the same edge.
                    if (checkEn && !halt) begin
                        errCode  <= ERR_DROP;
                        fail     <= 1'b1;
                        stateReg <= FAIL;
                    end else if (checkEn && (firstWord != wordAtHalt)) begin
                        errCode  <= ERR_WORD;
                        fail     <= 1'b1;
                        stateReg <= FAIL;
                    end else if (settleNext == SETTLE_LAST) begin
                        done     <= 1'b1;
                        stateReg <= DONE;
                    end
                end
                DONE, FAIL: begin
                    // Terminal until the next reset; every output holds.
                end
                default: stateReg <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_halt_monitor.sv
// Self-checking bench for halt_monitor: per-case expected results are queued as each
// scenario starts and popped when the monitor reports done/fail or the run window ends.
module tb_halt_monitor;

    logic        clk = 1'b0;
    logic        pwrOn;
    logic        halt;
    logic [15:0] firstWord;
    logic        checkEn;
    logic        done;
    logic        fail;
    logic [1:0]  errCode;
    logic [15:0] wordAtHalt;
    logic [31:0] clkAtHalt;
    logic [31:0] clkCnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        d;
        logic        f;
        logic [1:0]  e;
        logic [15:0] w;
        logic [31:0] at;
        logic [31:0] cnt;
    } expT;

    expT expQ[$];

    halt_monitor #(
        .TIMEOUT_CYCLES(3000),
        .SETTLE_CYCLES (5),
        .CNT_WIDTH     (32)
    ) dut (
        .clk       (clk),
        .pwrOn     (pwrOn),
        .halt      (halt),
        .firstWord (firstWord),
        .checkEn   (checkEn),
        .done      (done),
        .fail      (fail),
        .errCode   (errCode),
        .wordAtHalt(wordAtHalt),
        .clkAtHalt (clkAtHalt),
        .clkCnt    (clkCnt)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compareAll(input string tag, input expT e);
        checkVal({tag, ".done"}, 64'(done), 64'(e.d));
        checkVal({tag, ".fail"}, 64'(fail), 64'(e.f));
        checkVal({tag, ".errCode"}, 64'(errCode), 64'(e.e));
        checkVal({tag, ".wordAtHalt"}, 64'(wordAtHalt), 64'(e.w));
        checkVal({tag, ".clkAtHalt"}, 64'(clkAtHalt), 64'(e.at));
        checkVal({tag, ".clkCnt"}, 64'(clkCnt), 64'(e.cnt));
    endtask

    // Leaves the bench on a falling edge with pwrOn just released: the next rising edge is clkCnt=1.
    task automatic doReset();
        halt      = 1'b0;
        checkEn   = 1'b0;
        firstWord = 16'h0000;
        pwrOn     = 1'b0;
        repeat (2) @(negedge clk);
        pwrOn = 1'b1;
    endtask

    function automatic expT mkExp(input logic d, input logic f, input logic [1:0] e,
                                  input logic [15:0] w, input int at, input int cnt);
        expT r;
        r.d   = d;
        r.f   = f;
        r.e   = e;
        r.w   = w;
        r.at  = 32'(at);
        r.cnt = 32'(cnt);
        return r;
    endfunction

    // Drives edges 1..runLen (inputs set before each edge), stops at the first done/fail.
    task automatic runCase(input string tag, input bit doRst, input int haltAt, input logic [15:0] word,
                           input int dropAt, input int changeAt, input logic [15:0] changeWord,
                           input logic chk, input int runLen, input expT expIn);
        expT e;
        bit  seen;
        expQ.push_back(expIn);
        if (doRst) doReset();
        seen = 1'b0;
        for (int ed = 1; ed <= runLen && !seen; ed++) begin
            halt      = (haltAt != 0) && (ed >= haltAt) && !((dropAt != 0) && (ed >= dropAt));
            firstWord = ((changeAt != 0) && (ed >= changeAt)) ? changeWord : word;
            checkEn   = chk;
            @(negedge clk);
            if (done || fail) seen = 1'b1;
        end
        e = expQ.pop_front();
        checkVal({tag, ".terminal"}, 64'(seen), 64'(e.d | e.f));
        compareAll(tag, e);
        checkVal({tag, ".exclusive"}, 64'(done & fail), 64'd0);
        if (e.d || e.f) begin
            // Terminal states ignore inputs: wiggle them and confirm nothing moves.
            for (int k = 0; k < 4; k++) begin
                halt      = ~halt;
                firstWord = firstWord ^ 16'hA5A5;
                checkEn   = ~checkEn;
                @(negedge clk);
            end
            compareAll({tag, ".hold"}, e);
        end
        $display("txn %s done=%0b fail=%0b err=%0d word=%h at=%0d cnt=%0d",
                 tag, done, fail, errCode, wordAtHalt, clkAtHalt, clkCnt);
    endtask

    initial begin
        pwrOn     = 1'b0;
        halt      = 1'b0;
        checkEn   = 1'b0;
        firstWord = 16'h0000;
        #3;
        expQ.push_back(mkExp(1'b0, 1'b0, 2'd0, 16'h0000, 0, 0));
        compareAll("reset", expQ.pop_front());
        $display("txn reset cnt=%0d", clkCnt);

        runCase("halt100", 1'b1, 100, 16'h1234, 0, 0, 16'h0, 1'b1, 200,
                mkExp(1'b1, 1'b0, 2'd0, 16'h1234, 100, 105));
        runCase("timeout", 1'b1, 0, 16'h0000, 0, 0, 16'h0, 1'b1, 3100,
                mkExp(1'b0, 1'b1, 2'd1, 16'h0000, 0, 3001));
        runCase("noTimeout", 1'b1, 0, 16'h0000, 0, 0, 16'h0, 1'b0, 5000,
                mkExp(1'b0, 1'b0, 2'd0, 16'h0000, 0, 5000));
        runCase("haltDrop", 1'b1, 50, 16'h4321, 52, 0, 16'h0, 1'b1, 100,
                mkExp(1'b0, 1'b1, 2'd2, 16'h4321, 50, 52));
        runCase("wordChange", 1'b1, 50, 16'hBEEF, 0, 53, 16'hBEEE, 1'b1, 100,
                mkExp(1'b0, 1'b1, 2'd3, 16'hBEEF, 50, 53));
        runCase("wordChangeNoChk", 1'b1, 50, 16'hBEEF, 0, 53, 16'hBEEE, 1'b0, 100,
                mkExp(1'b1, 1'b0, 2'd0, 16'hBEEF, 50, 55));
        runCase("haltWins", 1'b1, 3001, 16'h0F0F, 0, 0, 16'h0, 1'b1, 3100,
                mkExp(1'b1, 1'b0, 2'd0, 16'h0F0F, 3001, 3006));

        // Asynchronous reset mid-settle: halt captured at 50, reset pulsed at clkCnt=52.
        doReset();
        for (int ed = 1; ed <= 52; ed++) begin
            halt      = (ed >= 50);
            firstWord = 16'h5555;
            checkEn   = 1'b1;
            @(negedge clk);
        end
        checkVal("preReset.clkAtHalt", 64'(clkAtHalt), 64'd50);
        #2;
        pwrOn = 1'b0;
        #1;
        expQ.push_back(mkExp(1'b0, 1'b0, 2'd0, 16'h0000, 0, 0));
        compareAll("asyncReset", expQ.pop_front());
        $display("txn asyncReset cnt=%0d word=%h", clkCnt, wordAtHalt);
        halt = 1'b0;
        @(negedge clk);
        pwrOn = 1'b1;
        runCase("afterReset", 1'b0, 10, 16'h00AA, 0, 0, 16'h0, 1'b1, 50,
                mkExp(1'b1, 1'b0, 2'd0, 16'h00AA, 10, 15));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
